// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: controller state enum, funct3 access codes, address-field width helpers.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  // funct3 encodings of the memory-stage access size/extension
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // word-in-line field width
  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // set-index field width
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // tag field width: whatever remains above index, word offset and byte offset
  function automatic int tag_bits(input int addr_width, input int sets, input int words_per_line);
    return addr_width - $clog2(sets) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/dcache_lane_merge.sv
// Store lane merge and load lane extract/extend for one 32-bit cache word.
// Latency: purely combinational.
// Backpressure: none; no handshake.
// Ports: ctrl (funct3), byte_off (addr[1:0]), wdata (right-aligned store data),
//        old_word (current cache word), merged_word (word after store), load_data (extended load).
module dcache_lane_merge
  import dcache_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Store: bytes use byte_off, halves use byte_off[1] only, everything else is a full word.
  always_comb begin
    merged_word = old_word;
    case (ctrl)
      MEM_B: begin
        case (byte_off)
          2'd0:    merged_word[7:0]   = wdata[7:0];
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          default: merged_word[31:24] = wdata[7:0];
        endcase
      end
      MEM_H: begin
        if (byte_off[1]) merged_word[31:16] = wdata[15:0];
        else             merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

  always_comb begin
    case (byte_off)
      2'd0:    ld_b = old_word[7:0];
      2'd1:    ld_b = old_word[15:8];
      2'd2:    ld_b = old_word[23:16];
      default: ld_b = old_word[31:24];
    endcase
    ld_h = byte_off[1] ? old_word[31:16] : old_word[15:0];
  end

  // Load: unlisted codes fall back to a full word
  always_comb begin
    case (ctrl)
      MEM_B:   load_data = {{24{ld_b[7]}}, ld_b};
      MEM_H:   load_data = {{16{ld_h[15]}}, ld_h};
      MEM_BU:  load_data = {24'd0, ld_b};
      MEM_HU:  load_data = {16'd0, ld_h};
      default: load_data = old_word;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate data cache serving memory-stage loads/stores.
// Latency: hits complete the same cycle (zero-latency load data); misses take WPL+1 (clean) or 2*WPL+1 (dirty) cycles minimum.
// Backpressure: req_ready low stalls the CPU during a miss; each beat waits for mem_ready.
// Ports: clk/rst (sync active-high); req_* CPU request, req_ready/rsp_rdata response;
//        mem_* word-serial backing-memory beats (mem_ready accepts, mem_rdata valid same cycle).
// Optional: define DCACHE_PERF_EN to add hit_count/miss_count outputs.
module data_cache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_ctrl,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_W  = off_bits(WORDS_PER_LINE);
  localparam int IDX_W  = idx_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, SETS, WORDS_PER_LINE);
  localparam int LINE_W = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_set;
  logic [OFF_W-1:0]  req_word;
  logic              hit;
  logic [DATA_WIDTH-1:0] hit_word, merged_word, load_data;

  logic              data_we, tag_we;
  logic [LINE_W-1:0] data_widx;
  logic [DATA_WIDTH-1:0] data_wdat;

  assign req_word = req_addr[OFF_W+1:2];
  assign req_set  = req_addr[OFF_W+2 +: IDX_W];
  assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign hit      = valid_q[req_set] && (tag_q[req_set] == req_tag);
  assign hit_word = data_q[{req_set, req_word}];

  dcache_lane_merge u_lane (
    .ctrl        (req_ctrl),
    .byte_off    (req_addr[1:0]),
    .wdata       (req_wdata),
    .old_word    (hit_word),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_we    = 1'b0;
    data_we   = 1'b0;
    data_widx = {req_set, req_word};
    data_wdat = merged_word;
    req_ready = 1'b0;
    rsp_rdata = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = !req_valid || hit;
        if (req_valid && hit) begin
          if (req_write) begin
            data_we          = 1'b1;
            dirty_d[req_set] = 1'b1;
          end else begin
            rsp_rdata = load_data;
          end
        end else if (req_valid) begin
          cnt_d = '0;
          if (dirty_q[req_set] && valid_q[req_set]) begin
            state_d = WRITEBACK;
          end else begin
            // line is about to be overwritten piecewise; it must not look valid meanwhile
            state_d          = FILL;
            valid_d[req_set] = 1'b0;
          end
        end
      end
      WRITEBACK: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_set], req_set, cnt_q, 2'b00};
        mem_wdata = data_q[{req_set, cnt_q}];
        if (mem_ready) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d          = FILL;
            cnt_d            = '0;
            valid_d[req_set] = 1'b0;
            dirty_d[req_set] = 1'b0;
          end
        end
      end
      FILL: begin
        mem_valid = 1'b1;
        mem_addr  = {req_tag, req_set, cnt_q, 2'b00};
        if (mem_ready) begin
          data_we   = 1'b1;
          data_widx = {req_set, cnt_q};
          data_wdat = mem_rdata;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d          = IDLE;
            cnt_d            = '0;
            tag_we           = 1'b1;
            valid_d[req_set] = 1'b1;
            dirty_d[req_set] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Arrays hold no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_q[data_widx] <= data_wdat;
    if (!rst && tag_we)  tag_q[req_set]    <= req_tag;
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        missed_q, missed_d;  // current request already went through a miss sequence

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    missed_d     = missed_q;
    if (state_q == IDLE) begin
      if (!req_valid) begin
        missed_d = 1'b0;
      end else if (hit) begin
        if (missed_q) miss_count_d = miss_count_q + 32'd1;
        else          hit_count_d  = hit_count_q + 32'd1;
        missed_d = 1'b0;
      end else begin
        missed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      missed_q     <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      missed_q     <= missed_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed accesses checked against an architectural memory model
// plus a set/tag/dirty predictor that yields expected bursts, stall lengths and load data.
module tb_data_cache;

  localparam logic [2:0] C_B = 3'b000, C_H = 3'b001, C_W = 3'b010, C_BU = 3'b100, C_HU = 3'b101;

  logic        clk, rst;
  logic        req_valid, req_write;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_rdata (rsp_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- models ----------------
  logic [31:0] bmem [logic [31:0]];   // backing memory overrides (written-back words)
  logic [7:0]  amem [logic [31:0]];   // CPU-visible byte overrides (stores not yet reflected below)
  bit          mv [64];
  bit          md [64];
  logic [31:0] mt [64];
  int          m_hits = 0, m_miss = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t exp_q[$];

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [31:0] bw, w;
    bw = bmem_rd(a);
    w  = bw;
    for (int k = 0; k < 4; k++)
      if (amem.exists(a + k)) w[8*k +: 8] = amem[a + k];
    return w;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] c, input logic [31:0] a);
    logic [31:0] w, sb, sh;
    w  = arch_word(a & ~32'h3);
    sb = w >> (8 * (a & 32'h3));
    sh = w >> (16 * ((a >> 1) & 32'h1));
    case (c)
      C_B:     return {{24{sb[7]}}, sb[7:0]};
      C_BU:    return {24'd0, sb[7:0]};
      C_H:     return {{16{sh[15]}}, sh[15:0]};
      C_HU:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic arch_store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] base;
    case (c)
      C_B: amem[a] = d[7:0];
      C_H: begin
        base = a & ~32'h1;
        amem[base] = d[7:0];
        amem[base + 1] = d[15:8];
      end
      default: begin
        base = a & ~32'h3;
        for (int k = 0; k < 4; k++) amem[base + k] = d[8*k +: 8];
      end
    endcase
  endtask

  // ---------------- compare process ----------------
  bit          chk_en = 0;
  int          exp_stall = -1;
  logic [31:0] exp_rdata = 0;
  int          stall_cnt = 0;
  int          last_stall = 0;
  logic [31:0] last_rdata = 0;
  bit          first_wb_seen = 0;
  logic [31:0] first_wb_data = 0;

  always @(negedge clk) begin
    beat_t b;
    if (!chk_en) begin
      stall_cnt = 0;
    end else begin
      if (req_valid && !req_ready) stall_cnt++;
      if (req_valid && req_ready) begin
        if (exp_stall >= 0) chk("stall_cycles", stall_cnt, exp_stall);
        last_stall = stall_cnt;
        stall_cnt  = 0;
        if (!req_write) begin
          chk("load_rdata", rsp_rdata, exp_rdata);
          last_rdata = rsp_rdata;
        end
      end
      if (!(req_valid && req_ready && !req_write)) chk("rdata_idle_zero", rsp_rdata, 32'h0);
      if (mem_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {31'd0, mem_valid}, 32'h0);
        end else if (mem_ready) begin
          b = exp_q.pop_front();
          chk("beat_we", {31'd0, mem_we}, {31'd0, b.we});
          chk("beat_addr", mem_addr, b.addr);
          if (b.we) begin
            chk("beat_wdata", mem_wdata, b.data);
            if (!first_wb_seen) begin
              first_wb_seen = 1;
              first_wb_data = mem_wdata;
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input bit w, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] d, input bit tog);
    int          set;
    logic [31:0] tag, vbase, lbase;
    bit          hit, dirty_victim, done;
    set   = int'((a >> 4) & 32'h3F);
    tag   = a >> 10;
    lbase = a & ~32'hF;
    hit   = mv[set] && (mt[set] == tag);
    dirty_victim = !hit && mv[set] && md[set];
    if (!hit) begin
      if (dirty_victim) begin
        vbase = (mt[set] << 10) | (lbase & 32'h3F0);
        for (int k = 0; k < 4; k++) exp_q.push_back('{1'b1, vbase + 4*k, arch_word(vbase + 4*k)});
      end
      for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, lbase + 4*k, 32'h0});
    end
    exp_stall = tog ? -1 : (hit ? 0 : (dirty_victim ? 9 : 5));
    exp_rdata = w ? 32'h0 : load_val(c, a);
    if (hit) m_hits++; else m_miss++;
    req_valid = 1'b1;
    req_write = w;
    req_ctrl  = c;
    req_addr  = a;
    req_wdata = d;
    if (tog) mem_ready = 1'b0;
    done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (mem_valid && mem_we && mem_ready) bmem[mem_addr] = mem_wdata;
      mem_rdata = bmem_rd(mem_addr);
      if (req_ready) done = 1;
      else begin
        @(posedge clk); #1;
        if (tog) mem_ready = !mem_ready;
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    chk("beats_left", exp_q.size(), 32'd0);
    exp_q.delete();
    if (!hit) begin
      mv[set] = 1;
      mt[set] = tag;
      md[set] = 0;
    end
    if (w) begin
      md[set] = 1;
      arch_store(c, a, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 0; req_write = 0; req_ctrl = C_W; req_addr = 0; req_wdata = 0;
    mem_ready = 1'b1; mem_rdata = 0;
    for (int i = 0; i < 64; i++) begin mv[i] = 0; md[i] = 0; mt[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
`ifdef DCACHE_PERF_EN
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk); #1;
    chk_en = 1;

    do_access(0, C_W, 32'h100, 0, 0);
    chk("cold_lw_rdata", last_rdata, 32'hA5A5_0100);
    chk("cold_lw_stall", last_stall, 32'd5);
    do_access(0, C_W, 32'h104, 0, 0);
    chk("hit_lw_rdata", last_rdata, 32'hA5A5_0104);
    chk("hit_lw_stall", last_stall, 32'd0);
    do_access(1, C_B, 32'h101, 32'h0000_00AB, 0);
    do_access(0, C_B, 32'h101, 0, 0);
    chk("lb_rdata", last_rdata, 32'hFFFF_FFAB);
    do_access(0, C_BU, 32'h101, 0, 0);
    chk("lbu_rdata", last_rdata, 32'h0000_00AB);
    do_access(0, C_W, 32'h100, 0, 0);
    chk("lw_merged_rdata", last_rdata, 32'hA5A5_AB00);
    do_access(0, C_H, 32'h102, 0, 0);
    chk("lh_rdata", last_rdata, 32'hFFFF_A5A5);
    do_access(0, C_HU, 32'h101, 0, 0);
    do_access(1, C_H, 32'h10B, 32'h5555_1234, 0);
    do_access(0, C_W, 32'h108, 0, 0);
    chk("sh_lw_rdata", last_rdata, 32'h1234_0108);
    do_access(1, C_W, 32'h10E, 32'hDEAD_BEEF, 0);
    do_access(0, C_W, 32'h10C, 0, 0);
    do_access(0, 3'b111, 32'h10D, 0, 0);

    // dirty conflict in set 0x10
    do_access(0, C_W, 32'h500, 0, 0);
    chk("conflict_rdata", last_rdata, 32'hA5A5_0500);
    chk("conflict_stall", last_stall, 32'd9);
    chk("first_wb_data", first_wb_data, 32'hA5A5_AB00);
    do_access(0, C_W, 32'h100, 0, 0);
    chk("refetch_rdata", last_rdata, 32'hA5A5_AB00);

    // store miss allocates, then merges
    do_access(1, C_W, 32'h204, 32'hCAFE_F00D, 0);
    chk("store_miss_stall", last_stall, 32'd5);
    do_access(0, C_W, 32'h204, 0, 0);
    chk("store_miss_rdata", last_rdata, 32'hCAFE_F00D);

    // fill with mem_ready toggling
    do_access(0, C_W, 32'h300, 0, 1);
    chk("toggle_rdata", last_rdata, 32'hA5A5_0300);

    // reset during the second fill beat
    chk_en = 0;
    req_valid = 1; req_write = 0; req_ctrl = C_W; req_addr = 32'h700;
    @(negedge clk); mem_rdata = bmem_rd(mem_addr);
    @(posedge clk); #1;
    @(negedge clk); mem_rdata = bmem_rd(mem_addr);
    chk("rst_fill_beat0_addr", mem_addr, 32'h700);
    @(posedge clk); #1;
    chk("rst_fill_beat1_addr", mem_addr, 32'h704);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 0;
    @(negedge clk);
    chk("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 64; i++) begin mv[i] = 0; md[i] = 0; end
    amem.delete();
    exp_q.delete();
    m_hits = 0;
    m_miss = 0;
    @(posedge clk); #1;
    chk_en = 1;
    do_access(0, C_W, 32'h100, 0, 0);
    chk("post_rst_miss_stall", last_stall, 32'd5);
    chk("post_rst_rdata", last_rdata, 32'hA5A5_AB00);
    do_access(0, C_W, 32'h204, 0, 0);
    chk("dirty_lost_rdata", last_rdata, 32'hA5A5_0204);
    do_access(0, C_W, 32'h104, 0, 0);

`ifdef DCACHE_PERF_EN
    @(negedge clk);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
    chk("hit_count_literal", hit_count, 32'd1);
    chk("miss_count_literal", miss_count, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
